// File: rtl/tlb_ctrl.sv
// tlb_ctrl: three-state sequencer for TLBP/TLBR/TLBWI/TLBWR between CP0 and the TLB array.
// Also owns the CP0 Random register, which TLBWR samples as its target index.
module tlb_ctrl #(
    parameter int TLBNUM = 16,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          op_valid,
    input  logic [1:0]    op_type,
    output logic          op_ready,
    input  logic [31:0]   cp0_entryhi,
    input  logic [31:0]   cp0_entrylo0,
    input  logic [31:0]   cp0_entrylo1,
    input  logic [31:0]   cp0_index,
    input  logic [IW-1:0] wired_val,
    input  logic          wired_we,
    output logic [IW-1:0] random_val,
    output logic [18:0]   s_vpn2,
    output logic [7:0]    s_asid,
    input  logic          s_found,
    input  logic [IW-1:0] s_index,
    output logic          we,
    output logic [IW-1:0] w_index,
    output logic [18:0]   w_vpn2,
    output logic [7:0]    w_asid,
    output logic          w_g,
    output logic [19:0]   w_pfn0,
    output logic [2:0]    w_c0,
    output logic          w_d0,
    output logic          w_v0,
    output logic [19:0]   w_pfn1,
    output logic [2:0]    w_c1,
    output logic          w_d1,
    output logic          w_v1,
    output logic [IW-1:0] r_index,
    input  logic [18:0]   r_vpn2,
    input  logic [7:0]    r_asid,
    input  logic          r_g,
    input  logic [19:0]   r_pfn0,
    input  logic [2:0]    r_c0,
    input  logic          r_d0,
    input  logic          r_v0,
    input  logic [19:0]   r_pfn1,
    input  logic [2:0]    r_c1,
    input  logic          r_d1,
    input  logic          r_v1,
    output logic          index_we,
    output logic [31:0]   index_wdata,
    output logic          entryhi_we,
    output logic [31:0]   entryhi_wdata,
    output logic          entrylo_we,
    output logic [31:0]   entrylo0_wdata,
    output logic [31:0]   entrylo1_wdata,
    output logic          done,
    output logic          refetch
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
    localparam logic [1:0] OP_P = 2'b00, OP_R = 2'b01, OP_WR = 2'b11;
    localparam logic [IW-1:0] MAX_IDX = IW'(TLBNUM - 1);
    localparam logic [IW-1:0] ONE = IW'(1);

    state_e        state_q, state_d;
    logic [1:0]    op_q;
    logic [31:0]   hi_q, lo0_q, lo1_q;
    logic [IW-1:0] tgt_q, rand_q, rand_d;
    logic [31:0]   idx_wb_q, hi_wb_q, lo0_wb_q, lo1_wb_q;
    logic          accept, exec_p, exec_r, unused_ok;

    assign op_ready = state_q == IDLE;
    assign accept   = op_valid && op_ready;
    assign exec_p   = state_q == EXEC && op_q == OP_P;
    assign exec_r   = state_q == EXEC && op_q == OP_R;

    always_comb begin
        state_d = state_q;
        rand_d  = (wired_we || rand_q <= wired_val) ? MAX_IDX : rand_q - ONE;
        state_d = state_q == IDLE ? (op_valid ? EXEC : IDLE) :
                  state_q == EXEC ? RESP : IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            rand_q   <= MAX_IDX;
            op_q     <= '0;
            hi_q     <= '0;
            lo0_q    <= '0;
            lo1_q    <= '0;
            tgt_q    <= '0;
            idx_wb_q <= '0;
            hi_wb_q  <= '0;
            lo0_wb_q <= '0;
            lo1_wb_q <= '0;
        end else begin
            state_q <= state_d;
            rand_q  <= rand_d;
            if (accept) begin
                op_q  <= op_type;
                hi_q  <= cp0_entryhi;
                lo0_q <= cp0_entrylo0;
                lo1_q <= cp0_entrylo1;
                // TLBWR uses Random as it stood before this cycle's update
                tgt_q <= op_type == OP_WR ? rand_q : cp0_index[IW-1:0];
            end
            if (exec_p)
                idx_wb_q <= {~s_found, {(31-IW){1'b0}}, s_found ? s_index : {IW{1'b0}}};
            if (exec_r) begin
                hi_wb_q  <= {r_vpn2, 5'b0, r_asid};
                lo0_wb_q <= {6'b0, r_pfn0, r_c0, r_d0, r_v0, r_g};
                lo1_wb_q <= {6'b0, r_pfn1, r_c1, r_d1, r_v1, r_g};
            end
        end
    end

    assign random_val     = rand_q;
    assign s_vpn2         = hi_q[31:13];
    assign s_asid         = hi_q[7:0];
    assign r_index        = tgt_q;
    assign we             = state_q == EXEC && op_q[1];
    assign w_index        = tgt_q;
    assign w_vpn2         = hi_q[31:13];
    assign w_asid         = hi_q[7:0];
    assign w_g            = lo0_q[0] & lo1_q[0];
    assign w_pfn0         = lo0_q[25:6];
    assign w_c0           = lo0_q[5:3];
    assign w_d0           = lo0_q[2];
    assign w_v0           = lo0_q[1];
    assign w_pfn1         = lo1_q[25:6];
    assign w_c1           = lo1_q[5:3];
    assign w_d1           = lo1_q[2];
    assign w_v1           = lo1_q[1];
    assign done           = state_q == RESP;
    assign refetch        = done && op_q != OP_P;
    assign index_we       = done && op_q == OP_P;
    assign entryhi_we     = done && op_q == OP_R;
    assign entrylo_we     = entryhi_we;
    assign index_wdata    = idx_wb_q;
    assign entryhi_wdata  = hi_wb_q;
    assign entrylo0_wdata = lo0_wb_q;
    assign entrylo1_wdata = lo1_wb_q;
    assign unused_ok      = ^{cp0_index[31:IW], hi_q[12:8], lo0_q[31:26], lo1_q[31:26]};
endmodule

// File: tb/tb_tlb_ctrl.sv
// tb_tlb_ctrl: directed bench for tlb_ctrl; write-back expectations queued at issue, checked at done.
module tb_tlb_ctrl;
    localparam int IW = 4;
    logic clk, resetn, op_valid, op_ready, wired_we, s_found, we, w_g, w_d0, w_v0, w_d1, w_v1;
    logic [1:0] op_type;
    logic [31:0] cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index;
    logic [IW-1:0] wired_val, random_val, s_index, w_index, r_index;
    logic [18:0] s_vpn2, w_vpn2, r_vpn2;
    logic [7:0] s_asid, w_asid, r_asid;
    logic [19:0] w_pfn0, w_pfn1, r_pfn0, r_pfn1;
    logic [2:0] w_c0, w_c1, r_c0, r_c1;
    logic r_g, r_d0, r_v0, r_d1, r_v1;
    logic index_we, entryhi_we, entrylo_we, done, refetch;
    logic [31:0] index_wdata, entryhi_wdata, entrylo0_wdata, entrylo1_wdata;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] idx;
        logic [31:0] hi;
        logic [31:0] lo0;
        logic [31:0] lo1;
    } exp_t;
    exp_t sb[$];
    int total = 0, bad = 0;

    tlb_ctrl dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_type(op_type), .op_ready(op_ready),
        .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
        .cp0_index(cp0_index), .wired_val(wired_val), .wired_we(wired_we), .random_val(random_val),
        .s_vpn2(s_vpn2), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
        .index_we(index_we), .index_wdata(index_wdata), .entryhi_we(entryhi_we),
        .entryhi_wdata(entryhi_wdata), .entrylo_we(entrylo_we),
        .entrylo0_wdata(entrylo0_wdata), .entrylo1_wdata(entrylo1_wdata),
        .done(done), .refetch(refetch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [31:0] idx, hi, lo0, lo1);
        exp_t e;
        e.op = op; e.idx = idx; e.hi = hi; e.lo0 = lo0; e.lo1 = lo1;
        sb.push_back(e);
    endtask

    // leaves the bench #1 after the accept edge, i.e. in EXEC
    task automatic issue(input logic [1:0] op, input logic [31:0] idx, hi);
        int n = 0;
        op_type = op; cp0_index = idx; cp0_entryhi = hi;
        cp0_entrylo0 = 32'h0000_0107; cp0_entrylo1 = 32'h0000_0147;
        op_valid = 1'b1;
        while (op_ready !== 1'b1 && n < 10) begin tick; n++; end
        chk("ready_before_issue", op_ready, 1);
        tick;
        op_valid = 1'b0;
    endtask

    task automatic resp;
        exp_t e;
        int n = 0;
        while (done !== 1'b1 && n < 4) begin tick; n++; end
        chk("done_pulse", done, 1);
        chk("sb_nonempty", 64'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("refetch", refetch, 64'(e.op != 2'b00));
            chk("index_we", index_we, 64'(e.op == 2'b00));
            chk("entryhi_we", entryhi_we, 64'(e.op == 2'b01));
            chk("entrylo_we", entrylo_we, 64'(e.op == 2'b01));
            if (e.op == 2'b00) chk("index_wdata", index_wdata, e.idx);
            if (e.op == 2'b01) begin
                chk("entryhi_wdata", entryhi_wdata, e.hi);
                chk("entrylo0_wdata", entrylo0_wdata, e.lo0);
                chk("entrylo1_wdata", entrylo1_wdata, e.lo1);
            end
        end
        tick;
        chk("done_cleared", done, 0);
        chk("ready_after", op_ready, 1);
    endtask

    initial begin
        logic hit;
        logic [IW-1:0] rmin;
        int n;
        resetn = 1'b0; op_valid = 1'b0; op_type = 2'b00; wired_we = 1'b0; wired_val = '0;
        cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0; cp0_index = '0;
        s_found = 1'b0; s_index = '0;
        r_vpn2 = 19'h00201; r_asid = 8'h12; r_g = 1'b1;
        r_pfn0 = 20'h4; r_c0 = 3'd0; r_d0 = 1'b1; r_v0 = 1'b1;
        r_pfn1 = 20'h5; r_c1 = 3'd0; r_d1 = 1'b1; r_v1 = 1'b1;
        #12;
        chk("rst_ready", op_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_we", we, 0);
        chk("rst_refetch", refetch, 0);
        chk("rst_index_wdata", index_wdata, 0);
        chk("rst_entryhi_wdata", entryhi_wdata, 0);
        chk("rst_w_index", w_index, 0);
        resetn = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            chk($sformatf("rand_walk%0d", k), random_val, 64'(15 - (k % 16)));
            chk("idle_ready", op_ready, 1);
            tick;
        end

        issue(2'b10, 32'd5, 32'h0040_2012);
        push(2'b10, 0, 0, 0, 0);
        chk("wi_we", we, 1);
        chk("wi_ready_low", op_ready, 0);
        chk("wi_w_index", w_index, 5);
        chk("wi_w_vpn2", w_vpn2, 19'h201);
        chk("wi_w_asid", w_asid, 8'h12);
        chk("wi_w_g", w_g, 1);
        chk("wi_w_page0", {w_pfn0, w_c0, w_d0, w_v0}, {20'h4, 3'd0, 1'b1, 1'b1});
        chk("wi_w_page1", {w_pfn1, w_c1, w_d1, w_v1}, {20'h5, 3'd0, 1'b1, 1'b1});
        tick;
        chk("wi_we_off_resp", we, 0);
        resp;

        s_found = 1'b1; s_index = 4'd5;
        issue(2'b00, 32'd0, 32'h0040_2012);
        push(2'b00, 32'h0000_0005, 0, 0, 0);
        chk("p_s_vpn2", s_vpn2, 19'h201);
        chk("p_s_asid", s_asid, 8'h12);
        chk("p_no_we", we, 0);
        tick;
        resp;

        s_found = 1'b0; s_index = 4'd9;
        issue(2'b00, 32'd0, 32'h1234_5678);
        push(2'b00, 32'h8000_0000, 0, 0, 0);
        tick;
        resp;

        issue(2'b01, 32'hFFFF_FFF5, 32'h0);
        push(2'b01, 0, 32'h0040_2012, 32'h0000_0107, 32'h0000_0147);
        chk("r_index", r_index, 5);
        chk("r_no_we", we, 0);
        tick;
        resp;

        wired_val = 4'd4;
        n = 0;
        while (random_val !== 4'd9 && n < 20) begin tick; n++; end
        chk("rand_reach9", random_val, 9);
        wired_we = 1'b1;
        issue(2'b11, 32'd2, 32'h0040_2012);
        wired_we = 1'b0;
        push(2'b11, 0, 0, 0, 0);
        chk("wr_we", we, 1);
        chk("wr_w_index", w_index, 9);
        chk("wr_rand_reload", random_val, 15);
        tick;
        resp;
        rmin = 4'd15;
        for (int k = 0; k < 30; k++) begin
            if (random_val < rmin) rmin = random_val;
            tick;
        end
        chk("rand_floor_wired", rmin, 4);

        s_found = 1'b0;
        push(2'b00, 32'h8000_0000, 0, 0, 0);
        push(2'b00, 32'h8000_0000, 0, 0, 0);
        op_type = 2'b00; op_valid = 1'b1;
        chk("b2b_ready_T", op_ready, 1);
        tick;
        chk("b2b_busy_T1", op_ready, 0);
        tick;
        chk("b2b_busy_T2", op_ready, 0);
        chk("b2b_done_T2", done, 1);
        tick;
        chk("b2b_ready_T3", op_ready, 1);
        tick;
        chk("b2b_accepted_T3", op_ready, 0);
        op_valid = 1'b0;
        sb.pop_front();
        tick;
        resp;

        op_type = 2'b10; cp0_index = 32'd3; op_valid = 1'b1;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        op_valid = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            hit = hit | we | done | refetch;
        end
        resetn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            hit = hit | we | done | refetch;
        end
        chk("abort_no_pulse", hit, 0);
        chk("abort_ready", op_ready, 1);
        chk("abort_index_wdata", index_wdata, 0);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tlb_ctrl.md
# tlb_ctrl

Sequencer for the MIPS TLB management instructions (TLBP, TLBR, TLBWI, TLBWR), sitting between the write-back stage / CP0 and the `tlb` array. Accepts one instruction at a time over a valid/ready handshake. Drives the array's write port, read port and a search request. Returns the results as CP0 register write-backs, plus a done/refetch pulse. Owns the CP0 Random register.

## Interface
Parameters:
- TLBNUM, 16, number of TLB entries (power of two); IW = $clog2(TLBNUM)

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- op_valid  in  1  instruction request
- op_type  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
- op_ready  out  1  controller can accept a request
- cp0_entryhi  in  32  VPN2 [31:13], ASID [7:0]
- cp0_entrylo0 / cp0_entrylo1  in  32 each  PFN [25:6], C [5:3], D [2], V [1], G [0]
- cp0_index  in  32  index field [IW-1:0]
- wired_val  in  IW  CP0 Wired
- wired_we  in  1  Wired is being written this cycle
- random_val  out  IW  CP0 Random
- s_vpn2 / s_asid  out  19 / 8  TLBP search key
- s_found / s_index  in  1 / IW  search result
- we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1  out  write port of `tlb`
- r_index  out  IW  read port index
- r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1  in  read port data
- index_we / index_wdata  out  1 / 32  CP0 Index write-back
- entryhi_we / entryhi_wdata  out  1 / 32
- entrylo_we / entrylo0_wdata / entrylo1_wdata  out  1 / 32 / 32
- done  out  1  one-cycle completion pulse
- refetch  out  1  one-cycle pulse with done for TLBR/TLBWI/TLBWR

## Operation
- FSM states: IDLE, EXEC, RESP. op_ready = (state==IDLE).
- IDLE: on op_valid && op_ready, register op_type, entryhi, entrylo0/1 and the target index, then go to EXEC.
  - Target index is cp0_index[IW-1:0] for TLBWI/TLBR.
  - Target index is the current random_val for TLBWR.
- EXEC: drive the TLB ports from the registered values for exactly one cycle, then go to RESP.
  - TLBP: s_vpn2/s_asid from the registered entryhi. Capture s_found and s_index.
  - TLBR: r_index = target. Capture all r_* fields.
  - TLBWI/TLBWR: we=1 with w_index = target.
    - w_vpn2 = entryhi[31:13]; w_asid = entryhi[7:0].
    - w_g = entrylo0[0] & entrylo1[0].
    - Page 0 fields (pfn/c/d/v) come from entrylo0; page 1 fields from entrylo1.
- RESP: pulse done, then return to IDLE.
  - TLBP: index_we=1, index_wdata = {~found, (31-IW)'b0, found ? s_index : 0}.
  - TLBR: entryhi_we=1, entryhi_wdata = {r_vpn2, 5'b0, r_asid}.
  - TLBR: entrylo_we=1, entrylo0_wdata = {6'b0, r_pfn0, r_c0, r_d0, r_v0, r_g}; entrylo1_wdata likewise from the page 1 fields.
  - TLBR/TLBWI/TLBWR: refetch=1. TLBP: refetch=0.
- Outside the cycles above, every *_we, we, done and refetch is 0.
- s_*, r_index and w_* data outputs hold their last values; only enables are qualified.
- Random register:
  - Every cycle, if random_val <= wired_val, next = TLBNUM-1; else next = random_val-1.
  - wired_we forces next = TLBNUM-1, with priority over decrement.
  - The value sampled for TLBWR is the value before that cycle's update, so a simultaneous wired_we does not affect the target.

## Timing
- Reset (async assert, sync-safe deassert):
  - state IDLE, so op_ready=1.
  - random_val = TLBNUM-1.
  - All enables, done and refetch = 0.
  - All data outputs and capture registers = 0.
- Accept at cycle T.
  - T+1: EXEC. The write occurs at the T+1→T+2 edge. Search and read results are sampled at the end of T+1.
  - T+2: RESP. done and write-backs asserted.
  - T+3: IDLE. Next accept possible at T+3, so throughput is 1 op / 3 cycles.
- op_valid while not ready is ignored. The requester holds it until accepted.
- TLBWI with index ≥ TLBNUM is not possible: only IW bits are used.
- resetn asserted mid-operation aborts the op; no write-back or done occurs. If reset arrives in EXEC before the edge, the TLB write is dropped.
- When wired_val = TLBNUM-1, random_val stays at TLBNUM-1.

## Test plan
- Reset, then idle for 20 cycles (wired=0) → random steps 15,14,…,0,15. op_ready=1 throughout.
- TLBWI with index=5, entryhi=0x0040_2012, lo0=0x0000_0107, lo1=0x0000_0147.
  - → At T+1: we=1, w_index=5, w_vpn2=0x201, w_asid=0x12, w_g=1, w_pfn0=0x4, w_c0=0, w_d0=1, w_v0=1, w_pfn1=0x5, w_c1=0, w_d1=1, w_v1=1.
  - → At T+2: done=1, refetch=1.
- TLBP, with search model returning found=1, index=5 → index_wdata=0x0000_0005. With found=0 → index_wdata=0x8000_0000. refetch=0 in both cases.
- TLBR index=5, read model returning the fields above.
  - → entryhi_wdata=0x0040_2012.
  - → entrylo0_wdata=0x0000_0107, entrylo1_wdata=0x0000_0147.
- TLBWR with wired=4 and random=9 at accept, wired_we pulsed in the same cycle → w_index=9. On the next cycle random=15. Random never goes below 4 afterwards.
- Back-to-back op_valid → second op accepted exactly at T+3. Reset pulse in EXEC of a TLBWI → we, done and refetch never assert.
